// File: rtl/mem_stage_lsu_if.sv
// Shared RISC-V types and the EX->MEM->WB signal bundle of the MEM-stage load/store unit.
package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW
    } operation_e;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        logic            valid;
    } rd_port_t;
endpackage

interface mem_stage_lsu_if;
    logic                       valid_i;
    logic [riscv_pkg::XLEN-1:0] pc_i;
    logic [riscv_pkg::XLEN-1:0] instr_i;
    riscv_pkg::operation_e      operation_i;
    riscv_pkg::rd_port_t        rd_port_i;
    logic [riscv_pkg::XLEN-1:0] addr_i;
    logic [riscv_pkg::XLEN-1:0] wdata_i;
    logic                       stall_o;
    logic                       valid_o;
    logic [riscv_pkg::XLEN-1:0] pc_o;
    logic [riscv_pkg::XLEN-1:0] instr_o;
    riscv_pkg::rd_port_t        rd_port_o;
    logic                       misalign_o;
    logic [riscv_pkg::XLEN-1:0] fault_addr_o;

    modport master (
        output valid_i, pc_i, instr_i, operation_i, rd_port_i, addr_i, wdata_i,
        input  stall_o, valid_o, pc_o, instr_o, rd_port_o, misalign_o, fault_addr_o
    );

    modport slave (
        input  valid_i, pc_i, instr_i, operation_i, rd_port_i, addr_i, wdata_i,
        output stall_o, valid_o, pc_o, instr_o, rd_port_o, misalign_o, fault_addr_o
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: byte-lane load/store unit with wait-state FSM, stall handshake
// and the registered MEM-WB boundary.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_stage_lsu_if.slave lsu_io
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    state_e          state_q;
    logic [2:0]      cnt_q;
    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    rd_port_t        rd_q,       rd_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] fault_q,    fault_d;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic            is_load, is_store, bad_align;
    logic            mem_op, misaligned, access, last_wait, stall, mem_we;
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic [XLEN-1:0] rd_word, load_data, store_data;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [3:0]      byte_en;

    assign word_idx = lsu_io.addr_i[AW+1:2];
    assign lane     = lsu_io.addr_i[1:0];
    assign rd_word  = mem_q[word_idx];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        bad_align = 1'b0;
        case (lsu_io.operation_i)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load  = 1'b1; bad_align = lane[0];  end
            OP_LW:         begin is_load  = 1'b1; bad_align = |lane;    end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; bad_align = lane[0];  end
            OP_SW:         begin is_store = 1'b1; bad_align = |lane;    end
            default:       ;
        endcase
    end

    assign mem_op     = lsu_io.valid_i && (is_load || is_store);
    assign misaligned = mem_op && bad_align;
    assign access     = mem_op && !bad_align;
    assign last_wait  = (LAST_CNT == 3'd0) || (state_q == ST_BUSY && cnt_q == LAST_CNT);
    // Reset forces the handshake low even while upstream still presents the aborted access.
    assign stall      = access && !last_wait && !rst_i;
    assign mem_we     = access && last_wait && is_store && !rst_i;

    always_comb begin
        sel_byte = rd_word[{lane, 3'b000} +: 8];
        sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (lsu_io.operation_i)
            OP_LB:   load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
            OP_LH:   load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
            OP_LHU:  load_data = {{(XLEN-16){1'b0}}, sel_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        byte_en    = 4'b1111;
        store_data = lsu_io.wdata_i;
        case (lsu_io.operation_i)
            OP_SB: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{lsu_io.wdata_i[7:0]}};
            end
            OP_SH: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{lsu_io.wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_d    = 1'b0;
        rd_d       = '0;
        misalign_d = 1'b0;
        fault_d    = '0;
        if (lsu_io.valid_i && !stall) begin
            valid_d = 1'b1;
            rd_d    = lsu_io.rd_port_i;
            if (misaligned) begin
                rd_d.valid = 1'b0;
                misalign_d = 1'b1;
                fault_d    = lsu_io.addr_i;
            end else if (is_load) begin
                rd_d.data = load_data;
            end
        end
    end

    // NOTE: the data array has no reset branch; clearing it would prevent RAM inference.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            instr_q    <= '0;
            rd_q       <= '0;
            misalign_q <= 1'b0;
            fault_q    <= '0;
        end else begin
            if (stall) begin
                state_q <= ST_BUSY;
                cnt_q   <= (state_q == ST_IDLE) ? 3'd1 : cnt_q + 3'd1;
            end else begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end
            valid_q    <= valid_d;
            pc_q       <= lsu_io.pc_i;
            instr_q    <= lsu_io.instr_i;
            rd_q       <= rd_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    assign lsu_io.stall_o      = stall;
    assign lsu_io.valid_o      = valid_q;
    assign lsu_io.pc_o         = pc_q;
    assign lsu_io.instr_o      = instr_q;
    assign lsu_io.rd_port_o    = rd_q;
    assign lsu_io.misalign_o   = misalign_q;
    assign lsu_io.fault_addr_o = fault_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu with WAIT_STATES=2: directed instructions, a
// word-level memory model and a per-cycle compare process.
module tb_mem_stage_lsu;
    import riscv_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_lsu_if bus();

    mem_stage_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(N)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .lsu_io (bus)
    );

    typedef enum {K_IDLE, K_BUBBLE, K_RESULT, K_MISAL} kind_e;
    typedef struct {
        logic        stall;
        kind_e       kind;
        rd_port_t    rd;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] fault;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_prev;
    exp_t        cur_e;
    bit          prev_known = 1'b0;
    bit          chk_en     = 1'b0;
    int          total      = 0;
    int          bad        = 0;
    logic [31:0] model_mem [int];
    logic [31:0] pc_cnt     = 32'h0000_1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic rd_port_t mkrd(input logic [4:0] a, input logic [31:0] d, input logic v);
        rd_port_t r;
        r.addr  = a;
        r.data  = d;
        r.valid = v;
        return r;
    endfunction

    function automatic exp_t mk(input logic stall, input kind_e kind, input rd_port_t rd,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] fault);
        exp_t e;
        e.stall = stall; e.kind = kind; e.rd = rd;
        e.pc = pc; e.instr = instr; e.fault = fault;
        return e;
    endfunction

    function automatic int op_size(input operation_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input operation_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] model_read(input int w);
        if (model_mem.exists(w)) return model_mem[w];
        return 32'h0;
    endfunction

    // Load value from plain shift/mask arithmetic on the word model.
    function automatic logic [31:0] model_load(input operation_e op, input logic [31:0] a);
        longint unsigned w, mask, raw;
        int sz;
        sz   = op_size(op);
        w    = longint'(model_read(word_of(a)));
        mask = (64'd1 << (8 * sz)) - 1;
        raw  = (w >> (8 * (a % 4))) & mask;
        if ((op == OP_LB || op == OP_LH) && raw >= (64'd1 << (8 * sz - 1)))
            raw = raw + (64'hFFFF_FFFF_FFFF_FFFF << (8 * sz));
        return raw[31:0];
    endfunction

    task automatic model_store(input operation_e op, input logic [31:0] a, input logic [31:0] d);
        longint unsigned w, mask;
        int sz;
        sz   = op_size(op);
        w    = longint'(model_read(word_of(a)));
        mask = ((64'd1 << (8 * sz)) - 1) << (8 * (a % 4));
        w    = (w & ~mask) | ((longint'(d) << (8 * (a % 4))) & mask);
        model_mem[word_of(a)] = w[31:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input operation_e op, input logic [31:0] a,
                         input logic [31:0] d, input rd_port_t rd,
                         input logic [31:0] pc, input logic [31:0] instr);
        bus.valid_i     = v;
        bus.operation_i = op;
        bus.addr_i      = a;
        bus.wdata_i     = d;
        bus.rd_port_i   = rd;
        bus.pc_i        = pc;
        bus.instr_i     = instr;
    endtask

    task automatic idle(input operation_e op);
        drive(1'b0, op, 32'h10, 32'h0, mkrd(5'd9, 32'h9999_9999, 1'b1), 32'hAAAA_0000, 32'hBBBB_0000);
        exp_q.push_back(mk(1'b0, K_IDLE, '0, 32'h0, 32'h0, 32'h0));
        step();
    endtask

    task automatic issue(input operation_e op, input logic [31:0] a, input logic [31:0] d,
                         input rd_port_t rd, input bit has_lit, input logic [31:0] lit);
        logic [31:0] pc, instr, v;
        rd_port_t    res;
        pc     = pc_cnt;
        instr  = 32'h0000_0003 ^ (pc << 8);
        pc_cnt = pc_cnt + 32'd4;
        drive(1'b1, op, a, d, rd, pc, instr);
        if (op_size(op) == 0) begin
            exp_q.push_back(mk(1'b0, K_RESULT, rd, pc, instr, 32'h0));
            step();
        end else if ((a % op_size(op)) != 0) begin
            exp_q.push_back(mk(1'b0, K_MISAL, rd, pc, instr, a));
            step();
        end else begin
            for (int c = 0; c < N; c++) begin
                exp_q.push_back(mk(1'b1, K_BUBBLE, rd, pc, instr, 32'h0));
                step();
            end
            res = rd;
            if (op_is_store(op)) begin
                model_store(op, a, d);
            end else begin
                v        = model_load(op, a);
                res.data = v;
                if (has_lit) check($sformatf("model %s @%0h", op.name(), a), {32'h0, v}, {32'h0, lit});
            end
            exp_q.push_back(mk(1'b0, K_RESULT, res, pc, instr, 32'h0));
            step();
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && exp_q.size() != 0) begin
            cur_e = exp_q.pop_front();
            check("stall_o", {63'h0, bus.stall_o}, {63'h0, cur_e.stall});
            if (prev_known) begin
                case (exp_prev.kind)
                    K_IDLE: begin
                        check("idle valid_o", {63'h0, bus.valid_o}, 64'h0);
                        check("idle rd_port_o", {26'h0, bus.rd_port_o}, 64'h0);
                        check("idle misalign_o", {63'h0, bus.misalign_o}, 64'h0);
                        check("idle fault_addr_o", {32'h0, bus.fault_addr_o}, 64'h0);
                    end
                    K_BUBBLE: begin
                        check("bubble valid_o", {63'h0, bus.valid_o}, 64'h0);
                        check("bubble rd valid", {63'h0, bus.rd_port_o.valid}, 64'h0);
                    end
                    K_RESULT: begin
                        check("result valid_o", {63'h0, bus.valid_o}, 64'h1);
                        check("result rd_port_o", {26'h0, bus.rd_port_o}, {26'h0, exp_prev.rd});
                        check("result pc_o", {32'h0, bus.pc_o}, {32'h0, exp_prev.pc});
                        check("result instr_o", {32'h0, bus.instr_o}, {32'h0, exp_prev.instr});
                        check("result misalign_o", {63'h0, bus.misalign_o}, 64'h0);
                        check("result fault_addr_o", {32'h0, bus.fault_addr_o}, 64'h0);
                    end
                    K_MISAL: begin
                        check("misal misalign_o", {63'h0, bus.misalign_o}, 64'h1);
                        check("misal fault_addr_o", {32'h0, bus.fault_addr_o}, {32'h0, exp_prev.fault});
                        check("misal rd valid", {63'h0, bus.rd_port_o.valid}, 64'h0);
                    end
                    default: ;
                endcase
            end
            exp_prev   = cur_e;
            prev_known = 1'b1;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " stall_o"}, {63'h0, bus.stall_o}, 64'h0);
        check({tag, " valid_o"}, {63'h0, bus.valid_o}, 64'h0);
        check({tag, " pc_o"}, {32'h0, bus.pc_o}, 64'h0);
        check({tag, " instr_o"}, {32'h0, bus.instr_o}, 64'h0);
        check({tag, " rd_port_o"}, {26'h0, bus.rd_port_o}, 64'h0);
        check({tag, " misalign_o"}, {63'h0, bus.misalign_o}, 64'h0);
        check({tag, " fault_addr_o"}, {32'h0, bus.fault_addr_o}, 64'h0);
    endtask

    task automatic resume_checking();
        exp_q.delete();
        exp_prev   = mk(1'b0, K_IDLE, '0, 32'h0, 32'h0, 32'h0);
        prev_known = 1'b1;
        chk_en     = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rd_port_t ld_rd, st_rd;
        logic [31:0] pc_abort;
        ld_rd = mkrd(5'd3, 32'h1111_1111, 1'b1);
        st_rd = mkrd(5'd0, 32'h2222_2222, 1'b0);

        drive(1'b0, OP_NOP, 32'h0, 32'h0, '0, 32'h0, 32'h0);
        #1 rst = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        step();
        resume_checking();

        // Word store with wait states, then read back
        issue(OP_SW, 32'h10, 32'hDEAD_BEEF, st_rd, 1'b0, 32'h0);
        issue(OP_LW, 32'h10, 32'h0, ld_rd, 1'b1, 32'hDEAD_BEEF);

        // Byte store and byte loads
        issue(OP_SB, 32'h13, 32'h0000_00AB, st_rd, 1'b0, 32'h0);
        issue(OP_LB, 32'h13, 32'h0, ld_rd, 1'b1, 32'hFFFF_FFAB);
        issue(OP_LBU, 32'h13, 32'h0, ld_rd, 1'b1, 32'h0000_00AB);
        issue(OP_LW, 32'h10, 32'h0, ld_rd, 1'b1, 32'hABAD_BEEF);

        // Halfword store and halfword loads
        issue(OP_SH, 32'h12, 32'h0000_8001, st_rd, 1'b0, 32'h0);
        issue(OP_LH, 32'h12, 32'h0, ld_rd, 1'b1, 32'hFFFF_8001);
        issue(OP_LHU, 32'h12, 32'h0, ld_rd, 1'b1, 32'h0000_8001);
        issue(OP_LW, 32'h10, 32'h0, ld_rd, 1'b1, 32'h8001_BEEF);

        // Remaining lanes, and an address above the array that wraps onto word 4
        issue(OP_LB, 32'h10, 32'h0, ld_rd, 1'b1, 32'hFFFF_FFEF);
        issue(OP_LBU, 32'h11, 32'h0, ld_rd, 1'b1, 32'h0000_00BE);
        issue(OP_LB, 32'h12, 32'h0, ld_rd, 1'b1, 32'h0000_0001);
        issue(OP_LH, 32'h10, 32'h0, ld_rd, 1'b1, 32'hFFFF_BEEF);
        issue(OP_LW, 32'h10 + 32'(DEPTH * 4), 32'h0, ld_rd, 1'b1, 32'h8001_BEEF);

        // Misaligned accesses: flagged, no write, no wait states
        issue(OP_LW, 32'h06, 32'h0, ld_rd, 1'b0, 32'h0);
        issue(OP_SH, 32'h11, 32'h0000_1234, st_rd, 1'b0, 32'h0);
        issue(OP_LHU, 32'h13, 32'h0, ld_rd, 1'b0, 32'h0);
        issue(OP_LW, 32'h10, 32'h0, ld_rd, 1'b1, 32'h8001_BEEF);

        // A store presented with valid_i low must not touch memory
        idle(OP_SW);
        idle(OP_NOP);
        issue(OP_LW, 32'h10, 32'h0, ld_rd, 1'b1, 32'h8001_BEEF);

        // Reset during BUSY aborts the store
        issue(OP_SW, 32'h20, 32'hCAFE_F00D, st_rd, 1'b0, 32'h0);
        pc_abort = pc_cnt;
        pc_cnt   = pc_cnt + 32'd4;
        drive(1'b1, OP_SW, 32'h20, 32'h1234_5678, st_rd, pc_abort, 32'h0000_0023);
        exp_q.push_back(mk(1'b1, K_BUBBLE, st_rd, pc_abort, 32'h0000_0023, 32'h0));
        step();
        chk_en     = 1'b0;
        prev_known = 1'b0;
        exp_q.delete();
        check("abort stall before reset", {63'h0, bus.stall_o}, 64'h1);
        rst = 1'b1;
        #1;
        check_all_zero("reset in busy");
        step();
        step();
        check_all_zero("reset held");
        @(negedge clk);
        drive(1'b0, OP_NOP, 32'h0, 32'h0, '0, 32'h0, 32'h0);
        rst = 1'b0;
        step();
        resume_checking();
        issue(OP_LW, 32'h20, 32'h0, ld_rd, 1'b1, 32'hCAFE_F00D);

        // Non-memory op passes straight through
        issue(OP_ADD, 32'h0, 32'h0, mkrd(5'd5, 32'h0000_0055, 1'b1), 1'b0, 32'h0);
        issue(OP_SUB, 32'h13, 32'h0, mkrd(5'd31, 32'hFFFF_0000, 1'b0), 1'b0, 32'h0);
        issue(OP_LB, 32'h13, 32'h0, ld_rd, 1'b1, 32'hFFFF_FF80);

        idle(OP_NOP);
        idle(OP_NOP);
        idle(OP_NOP);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
